// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// ALU operation codes and the decoded-instruction record.
package ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SHL  = 6'b011000;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Bit 3 only separates HALT from ID; the debug State output shows bits 2:0.
    typedef enum logic [3:0] {
        ST_IF     = 4'b0000,
        ST_ID     = 4'b0001,
        ST_EXE_AL = 4'b0110,
        ST_WB_AL  = 4'b0111,
        ST_EXE_BR = 4'b0101,
        ST_EXE_LS = 4'b0010,
        ST_MEM    = 4'b0011,
        ST_WB_LD  = 4'b0100,
        ST_HALT   = 4'b1001
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_ALU  = 3'd1,
        CL_BR   = 3'd2,
        CL_SW   = 3'd3,
        CL_LW   = 3'd4,
        CL_HALT = 3'd5
    } iclass_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b011,
        ALU_AND = 3'b100,
        ALU_SHL = 3'b101
    } aluop_t;

    typedef struct packed {
        iclass_t cls;
        aluop_t  aluop;
        logic    alusrcb;
        logic    extsel;
        logic    regout;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: instruction class plus ALU, extender and
// register-destination fields.
module mc_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '{cls: CL_NOP, aluop: ALU_ADD, alusrcb: 1'b0, extsel: 1'b1, regout: 1'b0};
        case (opcode)
            OP_ADD, OP_MOVE: begin
                dec.cls = CL_ALU; dec.extsel = 1'b0; dec.regout = 1'b1;
            end
            OP_SUB: begin
                dec.cls = CL_ALU; dec.aluop = ALU_SUB; dec.extsel = 1'b0; dec.regout = 1'b1;
            end
            OP_AND: begin
                dec.cls = CL_ALU; dec.aluop = ALU_AND; dec.extsel = 1'b0; dec.regout = 1'b1;
            end
            OP_OR: begin
                dec.cls = CL_ALU; dec.aluop = ALU_OR; dec.extsel = 1'b0; dec.regout = 1'b1;
            end
            OP_SHL: begin
                dec.cls = CL_ALU; dec.aluop = ALU_SHL; dec.alusrcb = 1'b1;
                dec.extsel = 1'b0; dec.regout = 1'b1;
            end
            OP_ADDI: begin
                dec.cls = CL_ALU; dec.alusrcb = 1'b1;
            end
            OP_ORI: begin
                dec.cls = CL_ALU; dec.aluop = ALU_OR; dec.alusrcb = 1'b1; dec.extsel = 1'b0;
            end
            OP_SW: begin
                dec.cls = CL_SW; dec.alusrcb = 1'b1;
            end
            OP_LW: begin
                dec.cls = CL_LW; dec.alusrcb = 1'b1;
            end
            OP_BEQ: begin
                dec.cls = CL_BR; dec.aluop = ALU_SUB;
            end
            OP_HALT: dec.cls = CL_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: IF/ID/EXE/MEM/WB sequencing with Moore-decoded
// datapath controls and a sticky HALT state.
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       ALUSrcB,
    output logic       ALUM2Reg,
    output logic       RegOut,
    output logic       RD,
    output logic       WR,
    output logic       PCSrc,
    output logic       ExtSel,
    output logic       insMemRW,
    output logic [2:0] ALUOp,
    output logic [2:0] State,
    output logic       Halted
);

    state_t st, nst;
    dec_t   dec, held, cur;

    mc_decode u_dec (
        .opcode (Opcode),
        .dec    (dec)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) st <= ST_IF;
        else        st <= nst;
    end

    // Decode captured in ID drives everything after it, so later Opcode
    // changes cannot redirect or alter an instruction already in flight.
    always_ff @(posedge CLK) begin
        if (!Reset)
            held <= '{cls: CL_NOP, aluop: ALU_ADD, alusrcb: 1'b0, extsel: 1'b1, regout: 1'b0};
        else if (st == ST_ID)
            held <= dec;
    end

    always_comb begin
        nst = ST_IF;
        case (st)
            ST_IF: nst = ST_ID;
            ST_ID: begin
                case (dec.cls)
                    CL_ALU:        nst = ST_EXE_AL;
                    CL_BR:         nst = ST_EXE_BR;
                    CL_SW, CL_LW:  nst = ST_EXE_LS;
                    CL_HALT:       nst = ST_HALT;
                    default:       nst = ST_IF;
                endcase
            end
            ST_EXE_AL: nst = ST_WB_AL;
            ST_EXE_LS: nst = ST_MEM;
            ST_MEM:    nst = (held.cls == CL_LW) ? ST_WB_LD : ST_IF;
            ST_HALT:   nst = ST_HALT;
            default:   nst = ST_IF;
        endcase
    end

    assign cur = (st == ST_ID) ? dec : held;

    always_comb begin
        PCWre    = 1'b0;
        IRWre    = 1'b0;
        RegWre   = 1'b0;
        ALUM2Reg = 1'b0;
        RD       = 1'b1;
        WR       = 1'b1;
        PCSrc    = 1'b0;
        Halted   = 1'b0;
        case (st)
            ST_IF:     IRWre = 1'b1;
            ST_ID:     PCWre = (dec.cls == CL_NOP);
            ST_WB_AL: begin
                PCWre = 1'b1; RegWre = 1'b1;
            end
            ST_EXE_BR: begin
                PCWre = 1'b1; PCSrc = Zero;
            end
            ST_MEM: begin
                if (held.cls == CL_LW) begin
                    RD = 1'b0; ALUM2Reg = 1'b1;
                end else begin
                    WR = 1'b0; PCWre = 1'b1;
                end
            end
            ST_WB_LD: begin
                PCWre = 1'b1; RegWre = 1'b1; ALUM2Reg = 1'b1;
            end
            ST_HALT:   Halted = 1'b1;
            default: ;
        endcase
        if (!Reset) begin
            PCWre    = 1'b0;
            IRWre    = 1'b0;
            RegWre   = 1'b0;
            ALUM2Reg = 1'b0;
            RD       = 1'b1;
            WR       = 1'b1;
            PCSrc    = 1'b0;
            Halted   = 1'b0;
        end
    end

    assign ALUOp    = cur.aluop;
    assign ALUSrcB  = cur.alusrcb;
    assign ExtSel   = cur.extsel;
    assign RegOut   = cur.regout;
    assign insMemRW = 1'b1;
    assign State    = Reset ? st[2:0] : 3'b000;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed and random instruction
// streams compared against a position-in-instruction reference model.
module tb_multi_cycle_ctrl;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] Opcode = '0;
    logic       Zero = 1'b0;
    logic       PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, RegOut;
    logic       RD, WR, PCSrc, ExtSel, insMemRW, Halted;
    logic [2:0] ALUOp, State;

    int total = 0;
    int bad = 0;

    localparam int K_NOP = 0, K_ALU = 1, K_BR = 2, K_SW = 3, K_LW = 4, K_HALT = 5;

    multi_cycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcB(ALUSrcB),
        .ALUM2Reg(ALUM2Reg), .RegOut(RegOut), .RD(RD), .WR(WR), .PCSrc(PCSrc),
        .ExtSel(ExtSel), .insMemRW(insMemRW), .ALUOp(ALUOp), .State(State),
        .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b010000,
            6'b010001, 6'b010010, 6'b011000, 6'b100000: return K_ALU;
            6'b110000: return K_BR;
            6'b100110: return K_SW;
            6'b100111: return K_LW;
            6'b111111: return K_HALT;
            default:   return K_NOP;
        endcase
    endfunction

    // State codes visited, in order, by one instruction of each kind.
    function automatic void seq_of(input int k, output logic [2:0] s[$]);
        case (k)
            K_ALU:   s = '{3'd0, 3'd1, 3'd6, 3'd7};
            K_BR:    s = '{3'd0, 3'd1, 3'd5};
            K_SW:    s = '{3'd0, 3'd1, 3'd2, 3'd3};
            K_LW:    s = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
            default: s = '{3'd0, 3'd1};
        endcase
    endfunction

    // {ALUOp, ALUSrcB, ExtSel, RegOut} from the opcode table.
    function automatic logic [5:0] fields_of(input logic [5:0] op);
        logic [2:0] a;
        logic       srcb, rfmt;
        case (op)
            6'b000010, 6'b110000: a = 3'b001;
            6'b010000, 6'b010010: a = 3'b011;
            6'b010001:            a = 3'b100;
            6'b011000:            a = 3'b101;
            default:              a = 3'b000;
        endcase
        srcb = (op == 6'b000001) || (op == 6'b010000) || (op == 6'b100110) ||
               (op == 6'b100111) || (op == 6'b011000);
        rfmt = (op == 6'b000000) || (op == 6'b000010) || (op == 6'b010001) ||
               (op == 6'b010010) || (op == 6'b100000) || (op == 6'b011000);
        return {a, srcb, !(rfmt || op == 6'b010000), rfmt};
    endfunction

    task automatic check_reset_outputs(input string tag);
        logic [10:0] got, exp;
        got = {PCWre, IRWre, RegWre, PCSrc, ALUM2Reg, RD, WR, Halted, State};
        exp = {5'b00000, 2'b11, 1'b0, 3'b000};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input bit zero, input bit scramble);
        int k, n;
        logic [2:0] s[$];
        logic [8:0] got, exp;
        bit last;
        k = kind_of(op);
        seq_of(k, s);
        n = s.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (i <= 1) Opcode = op;
            else if (scramble) Opcode = 6'($urandom);
            Zero = (k == K_BR && i == 2) ? zero : 1'($urandom_range(0, 1));
            #1;
            last = (i == n - 1);
            total++;
            if (State !== s[i]) begin
                bad++;
                $display("FAIL state op=%b step=%0d: got=%b expected=%b", op, i, State, s[i]);
            end
            got = {PCWre, IRWre, RegWre, ALUM2Reg, RD, WR, PCSrc, Halted, insMemRW};
            exp = {last, i == 0, last && (k == K_ALU || k == K_LW), k == K_LW && i >= 3,
                   !(k == K_LW && i == 3), !(k == K_SW && i == 3),
                   k == K_BR && i == 2 && zero, 1'b0, 1'b1};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL ctl op=%b step=%0d: got=%b expected=%b", op, i, got, exp);
            end
            if (i >= 1 && k != K_NOP) begin
                total++;
                if ({ALUOp, ALUSrcB, ExtSel, RegOut} !== fields_of(op)) begin
                    bad++;
                    $display("FAIL fields op=%b step=%0d: got=%b expected=%b", op, i,
                             {ALUOp, ALUSrcB, ExtSel, RegOut}, fields_of(op));
                end
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            Opcode = 6'($urandom);
            Zero = 1'($urandom_range(0, 1));
            #1;
            check_reset_outputs("reset_hold");
        end
        @(posedge CLK);
        #1 Reset = 1'b1;
    endtask

    task automatic test_directed;
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b110000, 1'b1, 1'b0);
        run_instr(6'b110000, 1'b0, 1'b0);
        run_instr(6'b100111, 1'b0, 1'b0);
        run_instr(6'b100110, 1'b0, 1'b0);
        run_instr(6'b000111, 1'b0, 1'b0);
        run_instr(6'b011000, 1'b0, 1'b0);
        run_instr(6'b010000, 1'b0, 1'b0);
    endtask

    task automatic test_halt;
        @(negedge CLK);
        Opcode = 6'b111111;
        @(negedge CLK);
        #1;
        total++;
        if ({State, Halted, PCWre} !== 5'b001_0_0) begin
            bad++;
            $display("FAIL halt_id: got=%b expected=%b", {State, Halted, PCWre}, 5'b001_0_0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            Opcode = 6'($urandom);
            #1;
            total++;
            if ({State, Halted, PCWre, IRWre} !== 6'b001_1_0_0) begin
                bad++;
                $display("FAIL halt_hold cyc=%0d: got=%b expected=%b", i,
                         {State, Halted, PCWre, IRWre}, 6'b001_1_0_0);
            end
        end
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check_reset_outputs("halt_reset");
        @(posedge CLK);
        #1 Reset = 1'b1;
        run_instr(6'b000000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_sw;
        Opcode = 6'b100110;
        for (int i = 0; i < 4; i++) @(negedge CLK);
        #1;
        total++;
        if ({State, WR} !== 4'b011_0) begin
            bad++;
            $display("FAIL sw_mem_reached: got=%b expected=%b", {State, WR}, 4'b011_0);
        end
        Reset = 1'b0;
        #1;
        check_reset_outputs("sw_mem_reset");
        @(posedge CLK);
        #1;
        check_reset_outputs("sw_after_edge");
        Reset = 1'b1;
        #1;
        total++;
        if ({State, IRWre, WR, RegWre, PCWre} !== 7'b000_1_1_0_0) begin
            bad++;
            $display("FAIL sw_refetch: got=%b expected=%b",
                     {State, IRWre, WR, RegWre, PCWre}, 7'b000_1_1_0_0);
        end
        run_instr(6'b000001, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [5:0] pool[14] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                 6'b010010, 6'b011000, 6'b100000, 6'b100110, 6'b100111,
                                 6'b110000, 6'b000111, 6'b101010, 6'b001111};
        for (int i = 0; i < 60; i++)
            run_instr(pool[$urandom_range(0, 13)], 1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_mid_sw;
        test_halt;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameters: none; opcode, state and ALUOp encodings SHALL come from ctrl_pkg.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 Opcode  input  6  opcode field from instruction register; stable from ID onward.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 PCWre  output  1  PC write enable.
REQ-007 IRWre  output  1  instruction register write enable.
REQ-008 RegWre  output  1  register file write enable.
REQ-009 ALUSrcB  output  1  0=register, 1=extended immediate.
REQ-010 ALUM2Reg  output  1  0=ALU result, 1=data memory to register write data.
REQ-011 RegOut  output  1  1=rd, 0=rt as write register.
REQ-012 RD  output  1  data memory read, active-low.
REQ-013 WR  output  1  data memory write, active-low.
REQ-014 PCSrc  output  1  1=branch target, 0=PC+4.
REQ-015 ExtSel  output  1  1=sign extend, 0=zero extend.
REQ-016 insMemRW  output  1  instruction memory read; tied 1.
REQ-017 ALUOp  output  3  000 add, 001 sub, 011 or, 100 and, 101 shl.
REQ-018 State  output  3  current FSM state, for debug display.
REQ-019 Halted  output  1  high while in HALT.

Function
REQ-020 States: IF=000, ID=001, EXE_AL=110, WB_AL=111, EXE_BR=101, EXE_LS=010, MEM=011, WB_LD=100; HALT holds code 001 with Halted=1.
REQ-021 Transitions: IF->ID; ID->EXE_AL (add, addi, sub, ori, and, or, move, shl), ID->EXE_BR (beq), ID->EXE_LS (sw, lw), ID->HALT (halt), ID->IF (undefined opcode, treated as NOP).
REQ-022 Transitions: EXE_AL->WB_AL->IF; EXE_BR->IF; EXE_LS->MEM; MEM->IF (sw), MEM->WB_LD (lw); WB_LD->IF; HALT->HALT until reset.
REQ-023 Latency: ALU ops 4 cycles, beq 3, sw 4, lw 5, NOP 2.
REQ-024 Outputs SHALL be Moore-decoded from State and Opcode, except PCSrc, which also depends on Zero in EXE_BR.
REQ-025 IRWre=1 only in IF.
REQ-026 PCWre=1 only in the final state of each instruction: WB_AL, EXE_BR, MEM for sw, WB_LD, ID for NOP; never in HALT.
REQ-027 RegWre=1 only in WB_AL and WB_LD.
REQ-028 RD=0 only in MEM for lw; WR=0 only in MEM for sw; otherwise both 1.
REQ-029 PCSrc=Zero in EXE_BR; otherwise 0.
REQ-030 ALUOp, ALUSrcB, ExtSel and RegOut per opcode:
  - add/move/addi/sw/lw: add.
  - sub/beq: sub.
  - or/ori: or.
  - and: and.
  - shl: shl.
  - ALUSrcB=1 for addi/ori/sw/lw/shl.
  - ExtSel=0 only for ori and R-format.
  - RegOut=1 for R-format.
  - All held constant across EXE through WB of one instruction.
REQ-031 ALUM2Reg=1 in MEM and WB_LD for lw; otherwise 0.
REQ-032 An Opcode change outside IF SHALL NOT alter the state sequence already selected in ID.

Reset
REQ-033 Reset=0 at a rising edge SHALL force IF on that edge, including mid-instruction and from HALT.
REQ-034 While Reset=0, outputs SHALL be:
  - PCWre, IRWre, RegWre, PCSrc, ALUM2Reg = 0.
  - RD = WR = 1.
  - Halted = 0.
  - State = 000.
REQ-035 The first IF after Reset deasserts SHALL assert IRWre.

Structure
REQ-036 ctrl_pkg SHALL hold opcode constants (shared with the single-cycle decoder), state encodings and ALUOp codes.
REQ-037 One combinational sub-module, mc_decode, SHALL map Opcode to instruction class and ALU/ext/mux fields; the state register and output gating stay in multi_cycle_ctrl.

Verification
REQ-038 add (000000) after reset -> states 000,001,110,111,000; RegWre=1 only in 111; PCWre=1 only in 111; RegOut=1, ALUOp=000.
REQ-039 beq (110000) with Zero=1 in EXE_BR -> states 000,001,101,000; PCSrc=1 and PCWre=1 in 101; repeat with Zero=0 -> PCSrc=0.
REQ-040 lw (100111) -> states 000,001,010,011,100,000; RD=0 in 011; ALUM2Reg=1 in 011 and 100; RegWre=1 in 100; WR=1 throughout.
REQ-041 sw (100110) -> states 000,001,010,011,000; WR=0 and PCWre=1 in 011; RegWre=0 throughout.
REQ-042 halt (111111) -> Halted=1 and PCWre=0 indefinitely; Reset=0 for one edge -> State=000, Halted=0, then normal fetch.
REQ-043 Reset=0 asserted in MEM of sw -> next edge State=000, WR=1, no register or memory write; undefined opcode 000111 -> states 000,001,000 with PCWre=1 in 001.
